// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 32;

  // Owner of the read whose data arrives on mem_q in the current cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_grant.sv
// ============================================================================
// Module      : dmem_arb_grant
// Description : Grant decision between core and DMA for the shared data
//               memory. Default build: fixed core priority with a bounded
//               DMA wait (MAX_WAIT). With DMEM_ARB_ROUND_ROBIN_EN defined,
//               conflicts alternate between the two requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arb_grant #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_cpu_req,
  input  logic i_dma_req,
  output logic o_cpu_gnt,
  output logic o_dma_gnt
);

  logic w_conflict;
  logic w_cpu_gnt;
  logic w_dma_gnt;

  assign w_conflict = i_cpu_req & i_dma_req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN

  // 1 = DMA won the most recent conflict; reset value lets the core win first
  logic r_last_dma;

  assign w_cpu_gnt = i_cpu_req & ~(w_conflict & ~r_last_dma);
  assign w_dma_gnt = i_dma_req & ~w_cpu_gnt;

  // Remember the winner of each conflict so the next one goes the other way
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_dma <= 1'b1;
    end else if (w_conflict) begin
      r_last_dma <= w_dma_gnt;
    end
  end

`else

  localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0] r_wait_cnt;
  logic       w_dma_force;

  // Once the DMA has been refused MAX_WAIT times it takes the next conflict
  assign w_dma_force = (r_wait_cnt == C_MAX_WAIT);
  assign w_cpu_gnt   = i_cpu_req & ~(i_dma_req & w_dma_force);
  assign w_dma_gnt   = i_dma_req & ~w_cpu_gnt;

  // Count consecutive refused DMA cycles; any grant or idle cycle clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 4'd0;
    end else if (i_dma_req & ~w_dma_gnt) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end

`endif

  assign o_cpu_gnt = w_cpu_gnt;
  assign o_dma_gnt = w_dma_gnt;

endmodule

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Shares a single-port synchronous data memory (1-cycle read
//               latency) between the core data port and a DMA/loader port.
//               One access per cycle, read data routed back to its issuer.
//               Optional macro DMEM_ARB_ROUND_ROBIN_EN selects alternating
//               arbitration instead of core priority with a DMA wait bound.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_gnt,
  output logic              o_cpu_stall,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic              o_dma_gnt,
  output logic              o_dma_rvalid,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_wren,
  input  logic [DATA_W-1:0] i_mem_q
);

  logic   w_cpu_req;
  logic   w_dma_req;
  logic   w_cpu_gnt;
  logic   w_dma_gnt;
  owner_e r_rd_owner;

  // Requests are masked while reset is asserted so no grant can appear then
  assign w_cpu_req = i_cpu_req & rst_n;
  assign w_dma_req = i_dma_req & rst_n;

  dmem_arb_grant #(
    .MAX_WAIT (MAX_WAIT)
  ) u_grant (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_cpu_req (w_cpu_req),
    .i_dma_req (w_dma_req),
    .o_cpu_gnt (w_cpu_gnt),
    .o_dma_gnt (w_dma_gnt)
  );

  assign o_cpu_gnt   = w_cpu_gnt;
  assign o_dma_gnt   = w_dma_gnt;
  assign o_cpu_stall = w_cpu_req & ~w_cpu_gnt;

  // Steer the granted requester onto the memory port; idle port drives zeros
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wren  = 1'b0;
    if (w_cpu_gnt) begin
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
      o_mem_wren  = i_cpu_we;
    end else if (w_dma_gnt) begin
      o_mem_addr  = i_dma_addr;
      o_mem_wdata = i_dma_wdata;
      o_mem_wren  = i_dma_we;
    end
  end

  // Track who issued this cycle's read so next cycle's mem_q goes to them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_owner <= OWN_NONE;
    end else if (w_cpu_gnt & ~i_cpu_we) begin
      r_rd_owner <= OWN_CPU;
    end else if (w_dma_gnt & ~i_dma_we) begin
      r_rd_owner <= OWN_DMA;
    end else begin
      r_rd_owner <= OWN_NONE;
    end
  end

  assign o_cpu_rvalid = (r_rd_owner == OWN_CPU);
  assign o_dma_rvalid = (r_rd_owner == OWN_DMA);
  assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_q : '0;
  assign o_dma_rdata  = o_dma_rvalid ? i_mem_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Self-checking bench for dmem_port_arbiter: vector table,
//               directed multi-cycle sequences and a randomized run against
//               a transaction-level reference model. Honours the
//               DMEM_ARB_ROUND_ROBIN_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

  localparam int MAX_WAIT = 4;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [7:0]  cpu_addr, dma_addr;
  logic [31:0] cpu_wdata, dma_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_wren;
  logic [31:0] cpu_rdata, dma_rdata, mem_wdata, mem_q;
  logic [7:0]  mem_addr;

  int n_pass = 0;
  int n_chk  = 0;

  dmem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_gnt(cpu_gnt), .o_cpu_stall(cpu_stall), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
    .o_dma_gnt(dma_gnt), .o_dma_rvalid(dma_rvalid), .o_dma_rdata(dma_rdata),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wren(mem_wren), .i_mem_q(mem_q)
  );

  // Single-port synchronous memory, 1-cycle read latency
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    mem_q <= mem[mem_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drv(input logic cr, input logic cw, input logic [7:0] ca, input logic [31:0] cd,
                     input logic dr, input logic dw, input logic [7:0] da, input logic [31:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic cr; logic cw; logic [7:0] ca; logic [31:0] cd;
    logic dr; logic dw; logic [7:0] da; logic [31:0] dd;
    logic ecg; logic edg; logic ewren; logic [7:0] eaddr; logic [31:0] ewd;
    logic ecrv; logic edrv;
  } vec_t;

  vec_t vecs [8];

  // Randomized-run model state
  logic        m_cp, m_cw, m_dp, m_dw;
  logic [7:0]  m_ca, m_da;
  logic [31:0] m_cd, m_dd;
  logic [31:0] shadow [16];
  int          ret_owner;
  logic [31:0] ret_data;
  int          streak;
  logic        last_dma;

  initial begin
    rst_n = 1'b0;
    drv(1'b1, 1'b0, 8'h33, 32'h1, 1'b1, 1'b0, 8'h44, 32'h2);
    repeat (2) @(posedge clk);
    // Reset state: requests ignored, everything quiet
    @(negedge clk);
    chk("rst_cpu_gnt", cpu_gnt, 0);   chk("rst_dma_gnt", dma_gnt, 0);
    chk("rst_wren", mem_wren, 0);     chk("rst_addr", mem_addr, 0);
    chk("rst_stall", cpu_stall, 0);   chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dma_rvalid", dma_rvalid, 0); chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    @(posedge clk); #1;
    idle();
    rst_n = 1'b1;

    // ---------------- vector table ----------------
    vecs[0] = '{1'b1,1'b1,8'h05,32'hA5A5A5A5, 1'b0,1'b0,8'h00,32'h0,
                1'b1,1'b0,1'b1,8'h05,32'hA5A5A5A5, 1'b0,1'b0};
    vecs[1] = '{1'b0,1'b0,8'h00,32'h0, 1'b1,1'b1,8'h06,32'h5A5A5A5A,
                1'b0,1'b1,1'b1,8'h06,32'h5A5A5A5A, 1'b0,1'b0};
    vecs[2] = '{1'b1,1'b0,8'h07,32'h0, 1'b0,1'b0,8'h00,32'h0,
                1'b1,1'b0,1'b0,8'h07,32'h0, 1'b1,1'b0};
    vecs[3] = '{1'b0,1'b0,8'h00,32'h0, 1'b1,1'b0,8'h08,32'h77,
                1'b0,1'b1,1'b0,8'h08,32'h77, 1'b0,1'b1};
    vecs[4] = '{1'b1,1'b0,8'h09,32'h0, 1'b1,1'b0,8'h0A,32'h0,
                1'b1,1'b0,1'b0,8'h09,32'h0, 1'b1,1'b0};
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    vecs[5] = '{1'b1,1'b1,8'h0B,32'hB1, 1'b1,1'b0,8'h0C,32'hC0DE,
                1'b0,1'b1,1'b0,8'h0C,32'hC0DE, 1'b0,1'b1};
`else
    vecs[5] = '{1'b1,1'b1,8'h0B,32'hB1, 1'b1,1'b0,8'h0C,32'hC0DE,
                1'b1,1'b0,1'b1,8'h0B,32'hB1, 1'b0,1'b0};
`endif
    vecs[6] = '{1'b0,1'b1,8'h55,32'h9, 1'b1,1'b1,8'h0D,32'hD00D,
                1'b0,1'b1,1'b1,8'h0D,32'hD00D, 1'b0,1'b0};
    vecs[7] = '{1'b0,1'b1,8'h66,32'h9, 1'b0,1'b1,8'h0E,32'hEE,
                1'b0,1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0};

    for (int i = 0; i < 8; i++) begin
      drv(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
          vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd);
      @(negedge clk);
      chk($sformatf("vec%0d_cpu_gnt", i), cpu_gnt, vecs[i].ecg);
      chk($sformatf("vec%0d_dma_gnt", i), dma_gnt, vecs[i].edg);
      chk($sformatf("vec%0d_wren", i), mem_wren, vecs[i].ewren);
      chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].eaddr);
      chk($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].ewd);
      chk($sformatf("vec%0d_both_gnt", i), cpu_gnt & dma_gnt, 0);
      next_cycle();
      idle();
      @(negedge clk);
      chk($sformatf("vec%0d_cpu_rvalid", i), cpu_rvalid, vecs[i].ecrv);
      chk($sformatf("vec%0d_dma_rvalid", i), dma_rvalid, vecs[i].edrv);
      next_cycle();
    end

    // ---------------- core write then read ----------------
    drv(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk("t1_wr_gnt", cpu_gnt, 1); chk("t1_wr_wren", mem_wren, 1);
    next_cycle();
    drv(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk("t1_rd_gnt", cpu_gnt, 1); chk("t1_rd_wren", mem_wren, 0);
    chk("t1_wr_no_rvalid", cpu_rvalid, 0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("t1_cpu_rvalid", cpu_rvalid, 1); chk("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t1_dma_rvalid", dma_rvalid, 0); chk("t1_dma_rdata", dma_rdata, 0);
    next_cycle();
    @(negedge clk);
    chk("t1_rvalid_one_cycle", cpu_rvalid, 0);
    next_cycle();

    // ---------------- simultaneous reads ----------------
    drv(1'b1, 1'b1, 8'h01, 32'h11, 1'b0, 1'b0, 8'h00, 32'h0);
    next_cycle();
    drv(1'b1, 1'b1, 8'h02, 32'h22, 1'b0, 1'b0, 8'h00, 32'h0);
    next_cycle();
    drv(1'b1, 1'b0, 8'h01, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0);
    @(negedge clk);
    chk("t2_c1_cpu_gnt", cpu_gnt, 1); chk("t2_c1_dma_gnt", dma_gnt, 0);
    chk("t2_c1_addr", mem_addr, 8'h01);
    next_cycle();
    drv(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0);
    @(negedge clk);
    chk("t2_c2_dma_gnt", dma_gnt, 1); chk("t2_c2_addr", mem_addr, 8'h02);
    chk("t2_c2_cpu_rvalid", cpu_rvalid, 1); chk("t2_c2_cpu_rdata", cpu_rdata, 32'h11);
    chk("t2_c2_dma_rvalid", dma_rvalid, 0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("t2_c3_dma_rvalid", dma_rvalid, 1); chk("t2_c3_dma_rdata", dma_rdata, 32'h22);
    chk("t2_c3_cpu_rvalid", cpu_rvalid, 0); chk("t2_c3_cpu_rdata", cpu_rdata, 0);
    next_cycle();

    // ---------------- reset during an outstanding DMA read ----------------
    drv(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0);
    @(negedge clk);
    chk("t4_dma_gnt", dma_gnt, 1);
    #2;
    rst_n   = 1'b0;
    cpu_req = 1'b1;
    #1;
    chk("t4_rst_cpu_gnt", cpu_gnt, 0); chk("t4_rst_dma_gnt", dma_gnt, 0);
    chk("t4_rst_wren", mem_wren, 0);   chk("t4_rst_addr", mem_addr, 0);
    chk("t4_rst_stall", cpu_stall, 0);
    next_cycle();
    @(negedge clk);
    chk("t4_rst_dma_rvalid", dma_rvalid, 0); chk("t4_rst_dma_rdata", dma_rdata, 0);
    next_cycle();
    rst_n = 1'b1;
    drv(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk("t4_first_gnt", cpu_gnt, 1); chk("t4_post_dma_rvalid", dma_rvalid, 0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("t4_post_cpu_rvalid", cpu_rvalid, 1); chk("t4_post_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t4_post_dma_rvalid2", dma_rvalid, 0);
    next_cycle();

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // ---------------- alternating grants under continuous contention ----------------
    for (int k = 0; k < 6; k++) begin
      drv(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h30, 32'h0);
      @(negedge clk);
      chk($sformatf("t5_k%0d_cpu_gnt", k), cpu_gnt, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t5_k%0d_dma_gnt", k), dma_gnt, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("t5_k%0d_both", k), cpu_gnt & dma_gnt, 0);
      next_cycle();
    end
`else
    // ---------------- starvation bound, two rounds ----------------
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k <= MAX_WAIT; k++) begin
        drv(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h30, 32'h0);
        @(negedge clk);
        if (k < MAX_WAIT) begin
          chk($sformatf("t3_r%0d_k%0d_cpu_gnt", r, k), cpu_gnt, 1);
          chk($sformatf("t3_r%0d_k%0d_dma_gnt", r, k), dma_gnt, 0);
          chk($sformatf("t3_r%0d_k%0d_stall", r, k), cpu_stall, 0);
        end else begin
          chk($sformatf("t3_r%0d_force_dma_gnt", r), dma_gnt, 1);
          chk($sformatf("t3_r%0d_force_cpu_gnt", r), cpu_gnt, 0);
          chk($sformatf("t3_r%0d_force_stall", r), cpu_stall, 1);
          chk($sformatf("t3_r%0d_force_addr", r), mem_addr, 8'h30);
        end
        next_cycle();
      end
    end
`endif

    // ---------------- idle ----------------
    idle();
    next_cycle();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t6_%0d_wren", k), mem_wren, 0);
      chk($sformatf("t6_%0d_addr", k), mem_addr, 0);
      chk($sformatf("t6_%0d_cpu_rvalid", k), cpu_rvalid, 0);
      chk($sformatf("t6_%0d_dma_rvalid", k), dma_rvalid, 0);
      next_cycle();
    end

    // ---------------- randomized run against the transaction model ----------------
    do_reset();
    for (int a = 0; a < 16; a++) begin
      shadow[a] = $urandom();
      drv(1'b1, 1'b1, 8'h20 + 8'(a), shadow[a], 1'b0, 1'b0, 8'h00, 32'h0);
      next_cycle();
    end
    idle();
    next_cycle();
    m_cp = 1'b0; m_dp = 1'b0;
    m_cw = 1'b0; m_dw = 1'b0; m_ca = 8'h0; m_da = 8'h0; m_cd = 32'h0; m_dd = 32'h0;
    ret_owner = 0; ret_data = 32'h0; streak = 0; last_dma = 1'b1;

    for (int n = 0; n < 400; n++) begin
      logic both, dma_first, ecg, edg;
      logic [7:0]  eaddr;
      logic [31:0] ewd;
      logic        ewren;
      if (!m_cp && $urandom_range(0, 99) < 60) begin
        m_cp = 1'b1; m_cw = $urandom_range(0, 1) == 1;
        m_ca = 8'h20 + 8'($urandom_range(0, 15)); m_cd = $urandom();
      end
      if (!m_dp && $urandom_range(0, 99) < 50) begin
        m_dp = 1'b1; m_dw = $urandom_range(0, 1) == 1;
        m_da = 8'h20 + 8'($urandom_range(0, 15)); m_dd = $urandom();
      end
      drv(m_cp, m_cw, m_ca, m_cd, m_dp, m_dw, m_da, m_dd);
      @(negedge clk);
      both = m_cp && m_dp;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      dma_first = !last_dma;
`else
      dma_first = (streak == MAX_WAIT);
`endif
      ecg   = m_cp && !(both && dma_first);
      edg   = m_dp && !ecg;
      eaddr = ecg ? m_ca : (edg ? m_da : 8'h00);
      ewd   = ecg ? m_cd : (edg ? m_dd : 32'h0);
      ewren = ecg ? m_cw : (edg ? m_dw : 1'b0);
      chk("rnd_cpu_gnt", cpu_gnt, ecg);
      chk("rnd_dma_gnt", dma_gnt, edg);
      chk("rnd_stall", cpu_stall, m_cp && !ecg);
      chk("rnd_wren", mem_wren, ewren);
      chk("rnd_addr", mem_addr, eaddr);
      chk("rnd_wdata", mem_wdata, ewd);
      chk("rnd_cpu_rvalid", cpu_rvalid, ret_owner == 1);
      chk("rnd_cpu_rdata", cpu_rdata, (ret_owner == 1) ? ret_data : 32'h0);
      chk("rnd_dma_rvalid", dma_rvalid, ret_owner == 2);
      chk("rnd_dma_rdata", dma_rdata, (ret_owner == 2) ? ret_data : 32'h0);
      // advance the model by one transaction
      ret_owner = 0;
      if (ecg || edg) begin
        if (ewren) shadow[eaddr[3:0]] = ewd;
        else begin
          ret_owner = ecg ? 1 : 2;
          ret_data  = shadow[eaddr[3:0]];
        end
      end
      streak = (m_dp && !edg) ? streak + 1 : 0;
      if (both) last_dma = edg;
      if (ecg) m_cp = 1'b0;
      if (edg) m_dp = 1'b0;
      next_cycle();
    end

    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single-port synchronous data memory (8-bit word address, 32-bit data, 1-cycle read latency) between the MIPS core data port and a second requester (DMA/loader).
- Sits between both requesters and the data memory.
- Issues at most one memory access per cycle.
- Routes registered read data back to the requester that issued the read.
- Provides a stall to the core and a wait-bounded grant guarantee to the DMA.

Parameters:
ADDR_W, 8, memory word-address width
DATA_W, 32, memory data width
MAX_WAIT, 4, consecutive cycles the DMA may be refused before it is forced a grant (1..15)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  core requests an access this cycle
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  core word address
cpu_wdata  in  DATA_W  core write data
cpu_gnt  out  1  core access issued this cycle
cpu_stall  out  1  cpu_req & ~cpu_gnt
cpu_rvalid  out  1  core read data valid
cpu_rdata  out  DATA_W  core read data
dma_req / dma_we / dma_addr / dma_wdata  in  1/1/ADDR_W/DATA_W  DMA request, same meaning as the core signals
dma_gnt  out  1  DMA access issued this cycle
dma_rvalid  out  1  DMA read data valid
dma_rdata  out  DATA_W  DMA read data
mem_addr  out  ADDR_W  to memory address
mem_wdata  out  DATA_W  to memory data
mem_wren  out  1  to memory write enable
mem_q  in  DATA_W  memory read data, valid 1 cycle after the read address

Behaviour:
- Grants are combinational from the requests and registered state. Requester holds req/we/addr/wdata stable until it sees gnt. Exactly one access completes per grant cycle.
- Default arbitration is fixed priority: the core wins on conflict.
- Starvation guard:
  - wait_cnt (4-bit) increments each cycle dma_req=1 and dma_gnt=0.
  - It clears on dma_gnt or when dma_req=0.
  - When wait_cnt == MAX_WAIT, the DMA wins the next conflict and the core stalls.
- Mux: mem_addr/mem_wdata take the granted requester's values. With no grant, mem_addr = 0 and mem_wdata = 0. mem_wren = granted requester's we, else 0.
- Read return:
  - Registered rd_owner ∈ {NONE, CPU, DMA} records the owner of a granted read.
  - Next cycle, that owner's rvalid = 1 for exactly one cycle, and its rdata = mem_q.
  - The non-owner's rvalid = 0.
  - rdata is driven 0 whenever rvalid = 0.
- Writes produce no rvalid.
- Back-to-back reads from either or both requesters are sustained at 1 per cycle, with no bubbles.
- Reset (asynchronous, rst_n=0): wait_cnt=0, rd_owner=NONE, all gnt/rvalid/mem_wren = 0, rdata = 0.
  - A read in flight at reset is discarded; no rvalid follows deassertion.
- Requests while rst_n=0 are ignored. The first grant is possible in the first cycle after deassertion.
- Both requesters may not see gnt in the same cycle (invariant).

Optional Feature:
DMEM_ARB_ROUND_ROBIN_EN
- Defined: conflicts alternate. A 1-bit last_winner register grants the requester that did not win the previous conflict. last_winner resets to DMA, so the core wins the first conflict. The wait_cnt/MAX_WAIT logic is removed.
- Undefined: fixed core priority with the MAX_WAIT starvation guard, as above.

Decomposition:
- Package dmem_arb_pkg: owner_e enum {OWN_NONE, OWN_CPU, OWN_DMA}, plus constants DMEM_ADDR_W=8 and DMEM_DATA_W=32.
- One sub-module, dmem_arb_grant: grant decision only (fixed+starvation or round-robin) and its state. The top holds the mux and read-return tracking.

Test Plan:
1. Core-only: core writes 0xDEADBEEF to addr 0x10, then reads 0x10 -> cpu_gnt both cycles; mem_wren=1 then 0; cpu_rvalid=1 one cycle after the read with cpu_rdata=0xDEADBEEF; dma_rvalid stays 0.
2. Simultaneous reads: core at 0x01 and DMA at 0x02, memory holds 0x11/0x22 -> core granted first, DMA next cycle; rvalids one cycle each, in order, with 0x11 then 0x22 routed correctly.
3. Starvation (MAX_WAIT=4): core requests every cycle, DMA holds one request -> DMA refused 4 cycles, granted on the 5th; cpu_stall=1 that cycle; wait_cnt back to 0.
4. Reset mid-read: DMA read granted, rst_n pulled low before the next edge -> no dma_rvalid after release; all outputs 0 during reset.
5. Round-robin build (macro defined): both request continuously -> grants alternate CPU, DMA, CPU, DMA starting with CPU; never both gnt in one cycle.
6. Idle: no requests -> mem_wren=0, mem_addr=0, no rvalid for 10 cycles.
